// File: rtl/mem_sequencer_pkg.sv
// Shared types for the register/memory transfer sequencer.
//   MEM_ADDR_W     : width of the data-RAM address bus
//   u4/u8/u12/u16  : unsigned vector shorthands used across the block
//   mem_seq_op_t   : transfer kinds that the sequencer accepts
//   mem_seq_state_t: sequencer FSM states
//   seq_addr()     : RAM address of element k of a transfer based at I
package mem_sequencer_pkg;

    localparam int MEM_ADDR_W = 12;

    typedef logic [3:0]            u4;
    typedef logic [7:0]            u8;
    typedef logic [MEM_ADDR_W-1:0] u12;
    typedef logic [15:0]           u16;

    typedef enum logic [1:0] {
        STORE_REGS = 2'd0,  // LD [I],Vx : V0..Vx -> RAM[I..I+x]
        LOAD_REGS  = 2'd1,  // LD Vx,[I] : RAM[I..I+x] -> V0..Vx
        STORE_BCD  = 2'd2   // LD B,Vx   : BCD digits of Vx -> RAM[I..I+2]
    } mem_seq_op_t;

    // Encoding 3 of the op bus is reserved and never accepted.
    localparam logic [1:0] OP_RESERVED = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD      = 3'd2,
        LOAD_TAIL = 3'd3,
        BCD       = 3'd4,
        DONE      = 3'd5
    } mem_seq_state_t;

    // Only the low 12 bits of I address RAM; the sum wraps at 0xFFF.
    function automatic u12 seq_addr(input u16 base, input u4 k);
        return base[MEM_ADDR_W-1:0] + u12'(k);
    endfunction

endpackage

// File: rtl/mem_sequencer_bcd8.sv
// Combinational 8-bit binary to 3-digit BCD converter (double dabble).
//   bin      : value 0..255
//   hundreds : hundreds digit (0..2)
//   tens     : tens digit (0..9)
//   ones     : ones digit (0..9)
module bcd8
    import mem_sequencer_pkg::*;
(
    input  u8 bin,
    output u4 hundreds,
    output u4 tens,
    output u4 ones
);

    // [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary being shifted out
    logic [19:0] sr;
    u4           digits [3];

    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            // Any digit >= 5 would overflow past 9 after the shift; pre-add 3.
            for (int d = 0; d < 3; d++) begin
                if (sr[8 + 4*d +: 4] >= 4'd5) begin
                    sr[8 + 4*d +: 4] = sr[8 + 4*d +: 4] + 4'd3;
                end
            end
            sr = {sr[18:0], 1'b0};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign digits[gi] = sr[8 + 4*gi +: 4];
        end
    endgenerate

    assign ones     = digits[0];
    assign tens     = digits[1];
    assign hundreds = digits[2];

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer for the register-block / BCD memory instructions.
// Moves V0..Vx to or from RAM starting at I, or writes the BCD digits of Vx.
//   clk, rst            : clock, synchronous active-high reset
//   start, op, x, I, vx : request from execute, latched on acceptance
//   busy, done          : pipeline stall and one-cycle completion pulse
//   reg_raddr/reg_rdata : register-file read port (combinational read)
//   reg_we/waddr/wdata  : register-file write port
//   mem_re/we/addr/...  : RAM port, read data returns one cycle after mem_re
//   I_we, I_out         : write-back of the advanced I after block transfers
module mem_sequencer
    import mem_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  u4          x,
    input  u16         I,
    input  u8          vx,
    input  u8          reg_rdata,
    input  u8          mem_rdata,
    output logic       busy,
    output logic       done,
    output u4          reg_raddr,
    output logic       reg_we,
    output u4          reg_waddr,
    output u8          reg_wdata,
    output logic       mem_re,
    output logic       mem_we,
    output u12         mem_addr,
    output u8          mem_wdata,
    output logic       I_we,
    output u16         I_out
);

    mem_seq_state_t state_reg, state_next;
    u4              k_reg, k_next;
    mem_seq_op_t    op_reg, op_next;
    u4              x_reg, x_next;
    u16             i_reg, i_next;
    u8              vx_reg, vx_next;

    logic accept;
    u4    bcd_h, bcd_t, bcd_o;
    u4    bcd_digit;

    bcd8 u_bcd8 (
        .bin      (vx_reg),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    // Reset wins over a simultaneous start, so gate acceptance on rst too.
    assign accept = !rst && start && (state_reg == IDLE) && (op != OP_RESERVED);

    // Stall already in the accept cycle so execute holds the instruction.
    assign busy = (state_reg != IDLE) || accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            op_reg    <= STORE_REGS;
            x_reg     <= '0;
            i_reg     <= '0;
            vx_reg    <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            op_reg    <= op_next;
            x_reg     <= x_next;
            i_reg     <= i_next;
            vx_reg    <= vx_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        op_next    = op_reg;
        x_next     = x_reg;
        i_next     = i_reg;
        vx_next    = vx_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next = mem_seq_op_t'(op);
                    x_next  = x;
                    i_next  = I;
                    vx_next = vx;
                    k_next  = '0;
                    case (op)
                        2'd0:    state_next = STORE;
                        2'd1:    state_next = LOAD;
                        default: state_next = BCD;
                    endcase
                end
            end
            STORE: begin
                if (k_reg == x_reg) begin
                    state_next = DONE;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end
            LOAD: begin
                // Read data lags by one cycle, so the last write needs a tail cycle.
                if (k_reg == x_reg) begin
                    state_next = LOAD_TAIL;
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end
            LOAD_TAIL: begin
                state_next = DONE;
                k_next     = '0;
            end
            BCD: begin
                if (k_reg == 4'd2) begin
                    state_next = DONE;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                k_next     = '0;
            end
        endcase
    end

    always_comb begin
        case (k_reg)
            4'd0:    bcd_digit = bcd_h;
            4'd1:    bcd_digit = bcd_t;
            default: bcd_digit = bcd_o;
        endcase
    end

    // Output strobes and buses; everything idles at zero.
    always_comb begin
        done      = 1'b0;
        reg_raddr = '0;
        reg_we    = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        I_we      = 1'b0;
        I_out     = '0;

        case (state_reg)
            STORE: begin
                reg_raddr = k_reg;
                mem_we    = 1'b1;
                mem_addr  = seq_addr(i_reg, k_reg);
                mem_wdata = reg_rdata;
            end
            LOAD: begin
                mem_re   = 1'b1;
                mem_addr = seq_addr(i_reg, k_reg);
                // mem_rdata now holds the byte requested for k-1.
                if (k_reg != 4'd0) begin
                    reg_we    = 1'b1;
                    reg_waddr = k_reg - 4'd1;
                    reg_wdata = mem_rdata;
                end
            end
            LOAD_TAIL: begin
                reg_we    = 1'b1;
                reg_waddr = x_reg;
                reg_wdata = mem_rdata;
            end
            BCD: begin
                mem_we    = 1'b1;
                mem_addr  = seq_addr(i_reg, k_reg);
                mem_wdata = {4'd0, bcd_digit};
            end
            DONE: begin
                done = 1'b1;
                if (op_reg != STORE_BCD) begin
                    I_we  = 1'b1;
                    I_out = i_reg + u16'(x_reg) + 16'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_sequencer.sv
module tb_mem_sequencer;
    import mem_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [3:0]  x = 4'd0;
    logic [15:0] I = 16'd0;
    logic [7:0]  vx = 8'd0;
    logic [7:0]  reg_rdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic        busy, done, reg_we, mem_re, mem_we, I_we;
    logic [3:0]  reg_raddr, reg_waddr;
    logic [7:0]  reg_wdata, mem_wdata;
    logic [11:0] mem_addr;
    logic [15:0] I_out;

    mem_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .I(I), .vx(vx),
        .reg_rdata(reg_rdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .reg_raddr(reg_raddr), .reg_we(reg_we),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .mem_re(mem_re),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .I_we(I_we), .I_out(I_out)
    );

    always #5 clk = ~clk;

    // Environment: register file and RAM the DUT talks to
    logic [7:0] ram  [0:4095];
    logic [7:0] regs [0:15];
    // Reference model state
    logic [7:0] exp_ram  [0:4095];
    logic [7:0] exp_regs [0:15];

    assign reg_rdata = regs[reg_raddr];

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
        if (reg_we) regs[reg_waddr] = reg_wdata;
    end

    int done_cnt = 0, we_cnt = 0, both_cnt = 0, strobe_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_we) we_cnt++;
        if (mem_re && mem_we) both_cnt++;
        if (mem_re || mem_we || reg_we || I_we) strobe_cnt++;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Effect of one transfer, straight from the instruction semantics.
    task automatic model_apply(input logic [1:0] o, input logic [3:0] xx,
                               input logic [15:0] ii, input logic [7:0] v);
        int base;
        base = int'(ii[11:0]);
        if (o == 2'd0) begin
            for (int k = 0; k <= int'(xx); k++) exp_ram[(base + k) % 4096] = exp_regs[k];
        end else if (o == 2'd1) begin
            for (int k = 0; k <= int'(xx); k++) exp_regs[k] = exp_ram[(base + k) % 4096];
        end else if (o == 2'd2) begin
            exp_ram[base]              = v / 8'd100;
            exp_ram[(base + 1) % 4096] = (v / 8'd10) % 8'd10;
            exp_ram[(base + 2) % 4096] = v % 8'd10;
        end
    endtask

    task automatic cmp_state(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== exp_ram[i]) bad++;
        for (int i = 0; i < 16; i++) if (regs[i] !== exp_regs[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [3:0] xx,
                          input logic [15:0] ii, input logic [7:0] v, input int exp_lat,
                          input logic exp_iwe, input logic [15:0] exp_iout);
        int lat;
        bit seen;
        @(negedge clk);
        op = o; x = xx; I = ii; vx = v; start = 1'b1;
        #1;
        chk({name, ":busy_accept"}, 32'(busy), 32'd1);
        model_apply(o, xx, ii, v);
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (lat == 1) chk({name, ":first_strobe"}, 32'(mem_we | mem_re), 32'd1);
            if (done) begin
                seen = 1;
                chk({name, ":latency"}, 32'(lat), 32'(exp_lat));
                chk({name, ":I_we"}, 32'(I_we), 32'(exp_iwe));
                if (exp_iwe) chk({name, ":I_out"}, 32'(I_out), 32'(exp_iout));
            end
        end
        chk({name, ":done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        chk({name, ":after_done"}, 32'({done, busy, I_we}), 32'd0);
        cmp_state({name, ":state"});
        $display("[TB] %s op=%0d x=%0d I=0x%04h vx=0x%02h lat=%0d", name, o, xx, ii, v, lat);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  x;
        logic [15:0] i;
        logic [7:0]  vx;
        int          lat;
        logic        iwe;
        logic [15:0] iout;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int d0, w0, s0;
        logic [1:0]  ro;
        logic [3:0]  rx;
        logic [15:0] ri, rout;
        logic [7:0]  rv;
        int          rlat;

        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            exp_ram[i] = ram[i];
        end
        for (int i = 0; i < 16; i++) begin
            regs[i] = 8'($urandom);
            exp_regs[i] = regs[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'({busy, done, reg_we, mem_re, mem_we, I_we}), 32'd0);
        chk("reset_addr", 32'({reg_raddr, reg_waddr, mem_addr}), 32'd0);
        chk("reset_data", 32'({reg_wdata, mem_wdata}), 32'd0);
        chk("reset_iout", 32'(I_out), 32'd0);
        $display("[TB] reset state checked");

        // Reset has priority over a same-cycle start
        start = 1'b1; op = 2'd0; x = 4'd3; I = 16'h0900;
        #1;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        d0 = done_cnt; s0 = strobe_cnt;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        #1;
        chk("rst_prio_idle", 32'({busy, mem_we, mem_re}), 32'd0);
        repeat (8) @(negedge clk);
        chk("rst_prio_quiet", 32'((done_cnt - d0) + (strobe_cnt - s0)), 32'd0);
        $display("[TB] reset-vs-start priority checked");

        // Directed vectors
        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33;
        ram[12'h400] = 8'hAA; ram[12'h401] = 8'hBB;
        for (int i = 0; i < 16; i++) exp_regs[i] = regs[i];
        exp_ram[12'h400] = 8'hAA; exp_ram[12'h401] = 8'hBB;

        vecs[0] = '{2'd0, 4'd2,  16'h0300, 8'h00, 4,  1'b1, 16'h0303};
        vecs[1] = '{2'd1, 4'd1,  16'h0400, 8'h00, 4,  1'b1, 16'h0402};
        vecs[2] = '{2'd2, 4'd0,  16'h0500, 8'hFE, 4,  1'b0, 16'h0000};
        vecs[3] = '{2'd0, 4'd1,  16'h0FFF, 8'h00, 3,  1'b1, 16'h1001};
        vecs[4] = '{2'd0, 4'd0,  16'h0123, 8'h00, 2,  1'b1, 16'h0124};
        vecs[5] = '{2'd1, 4'd15, 16'hFFF8, 8'h00, 18, 1'b1, 16'h0008};
        vecs[6] = '{2'd2, 4'd7,  16'h0FFE, 8'h00, 4,  1'b0, 16'h0000};
        vecs[7] = '{2'd1, 4'd0,  16'h0200, 8'h00, 3,  1'b1, 16'h0201};

        for (int v = 0; v < 8; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].x, vecs[v].i, vecs[v].vx,
                   vecs[v].lat, vecs[v].iwe, vecs[v].iout);
            if (v == 2) begin
                chk("vec_store_0x302", 32'(ram[12'h302]), 32'h33);
                chk("vec_load_V1", 32'(regs[1]), 32'hBB);
                chk("vec_bcd_0x500", 32'({ram[12'h500], ram[12'h501], ram[12'h502]}), 32'h020504);
            end
            if (v == 3) chk("vec_wrap_0x000", 32'({ram[12'hFFF], ram[12'h000]}), 32'hAABB);
        end

        // Second start while busy, then reserved op while idle
        d0 = done_cnt;
        model_apply(2'd0, 4'd3, 16'h0600, 8'h00);
        @(negedge clk); start = 1'b1; op = 2'd0; x = 4'd3; I = 16'h0600;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 2'd1; x = 4'd5; I = 16'h0700;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        chk("dup_start_done_count", 32'(done_cnt - d0), 32'd1);
        cmp_state("dup_start_state");
        $display("[TB] start during busy ignored");

        d0 = done_cnt; s0 = strobe_cnt;
        @(negedge clk); start = 1'b1; op = 2'd3; x = 4'd2; I = 16'h0A00;
        #1;
        chk("op3_busy", 32'(busy), 32'd0);
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("op3_quiet", 32'((done_cnt - d0) + (strobe_cnt - s0)), 32'd0);
        cmp_state("op3_state");
        $display("[TB] reserved op ignored");

        // Reset during the second write of an x=3 STORE
        exp_ram[12'h800] = exp_regs[0];
        exp_ram[12'h801] = exp_regs[1];
        @(negedge clk); start = 1'b1; op = 2'd0; x = 4'd3; I = 16'h0800;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("mid_rst_second_write", 32'({mem_we, mem_addr}), 32'h1801);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid_rst_idle", 32'({busy, mem_we, mem_re, done, I_we}), 32'd0);
        d0 = done_cnt; w0 = we_cnt;
        repeat (8) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_no_writes", 32'(we_cnt - w0), 32'd0);
        cmp_state("mid_rst_state");
        $display("[TB] mid-transfer reset abandoned transfer");

        // Randomized transfers against the model
        for (int n = 0; n < 30; n++) begin
            ro = 2'($urandom_range(0, 2));
            rx = 4'($urandom_range(0, 15));
            ri = 16'($urandom);
            rv = 8'($urandom);
            rlat = (ro == 2'd0) ? int'(rx) + 2 : (ro == 2'd1) ? int'(rx) + 3 : 4;
            rout = ri + 16'(rx) + 16'd1;
            run_op($sformatf("rnd%0d", n), ro, rx, ri, rv, rlat, (ro != 2'd2), rout);
        end

        chk("re_we_exclusive", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
